// File: rtl/ss_entrada_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ss_entrada_pkg
//  Purpose  : Shared types and default parameter values for the operand-entry
//             subsystem (synchronisers, button debounce, operand capture).
//  Contents : estado_t    - capture FSM state (IDLE: no data, HOLD: data valid)
//             DEF_*       - default parameter values used by the modules
//  Revision : 1.0 - initial release
// ============================================================================
package ss_entrada_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } estado_t;

    localparam int DEF_WIDTH           = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage : ss_entrada_pkg
`default_nettype wire

// File: rtl/ss_entrada_captura_antirrebote.sv
`default_nettype none
// ============================================================================
//  Module   : antirrebote
//  Purpose  : Synchronises the raw push-button into the clk domain, filters it
//             and emits a one-cycle pulse when the filtered level rises.
//  Macro    : SS_ENTRADA_DEBOUNCE_EN - defined: a level change is accepted only
//             after DEBOUNCE_CYCLES consecutive differing samples.
//             Undefined: the filtered level simply follows the synchronised one.
//  Ports    : clk     - system clock
//             rst     - asynchronous reset, active-low
//             i_boton - raw asynchronous button, active-high
//             o_db    - filtered button level
//             o_rise  - one-cycle pulse after o_db goes 0->1
//  Revision : 1.0 - initial release
// ============================================================================
module antirrebote
    import ss_entrada_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
`ifdef SS_ENTRADA_DEBOUNCE_EN
   ,parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_boton,
    output logic o_db,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_s;
    logic                   r_db;
    logic                   r_db_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_boton};
        end
    end

    assign w_btn_s = r_sync[SYNC_STAGES-1];

`ifdef SS_ENTRADA_DEBOUNCE_EN
    // A width of at least one keeps the counter legal when DEBOUNCE_CYCLES is 1.
    localparam int               c_cnt_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // The counter tracks how many consecutive samples have disagreed with the
    // accepted level; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (w_btn_s == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
            r_db  <= w_btn_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db <= 1'b0;
        end else begin
            r_db <= w_btn_s;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_q <= 1'b0;
        end else begin
            r_db_q <= r_db;
        end
    end

    assign o_db   = r_db;
    assign o_rise = r_db & ~r_db_q;

endmodule : antirrebote
`default_nettype wire

// File: rtl/ss_entrada_captura.sv
`default_nettype none
// ============================================================================
//  Module   : ss_entrada_captura
//  Purpose  : Operand-entry front end for the Booth multiplier. Synchronises
//             operands A/B and the push-button, debounces the button and
//             captures both operands on each press, offering them to the core
//             through a valid/ready handshake. Presses arriving while a capture
//             is still pending are dropped and flagged on ovr.
//  Macro    : SS_ENTRADA_DEBOUNCE_EN - enables the button debounce counter;
//             when undefined DEBOUNCE_CYCLES has no effect.
//  Ports    : clk    - system clock
//             rst    - asynchronous reset, active-low
//             A, B   - raw asynchronous operands (WIDTH bits)
//             boton  - raw asynchronous push-button, active-high
//             ready  - core accepts the operands this cycle
//             valid  - captured operands available
//             _A, _B - captured operands
//             ovr    - one-cycle pulse: press dropped, capture still pending
//  Revision : 1.0 - initial release
// ============================================================================
module ss_entrada_captura
    import ss_entrada_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             boton,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] _A,
    output logic [WIDTH-1:0] _B,
    output logic             ovr
);

    if (WIDTH < 2 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("ss_entrada_captura: illegal parameter combination");
    end

    logic [WIDTH-1:0] r_sync_a [SYNC_STAGES];
    logic [WIDTH-1:0] r_sync_b [SYNC_STAGES];
    logic [WIDTH-1:0] w_a_s;
    logic [WIDTH-1:0] w_b_s;
    logic             w_db;
    logic             w_rise;
    logic             w_press;
    estado_t          r_estado;
    estado_t          w_estado_next;
    logic             w_load;
    logic             w_ovr_next;
    logic             r_ovr;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;

    // ------------------------------------------------------------------
    // Operand synchronisers. Multi-bit values are only sampled on a press,
    // long after they have settled, so per-bit chains are sufficient.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_a[i] <= '0;
                r_sync_b[i] <= '0;
            end
        end else begin
            r_sync_a[0] <= A;
            r_sync_b[0] <= B;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync_a[i] <= r_sync_a[i-1];
                r_sync_b[i] <= r_sync_b[i-1];
            end
        end
    end

    assign w_a_s = r_sync_a[SYNC_STAGES-1];
    assign w_b_s = r_sync_b[SYNC_STAGES-1];

    antirrebote #(
        .SYNC_STAGES     (SYNC_STAGES)
`ifdef SS_ENTRADA_DEBOUNCE_EN
       ,.DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
    ) u_antirrebote (
        .clk     (clk),
        .rst     (rst),
        .i_boton (boton),
        .o_db    (w_db),
        .o_rise  (w_rise)
    );

    // The rise pulse only exists while the filtered level is high; tying the
    // event to the level keeps a press meaningful only for an accepted press.
    assign w_press = w_rise & w_db;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado <= IDLE;
            r_ovr    <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
        end else begin
            r_estado <= w_estado_next;
            r_ovr    <= w_ovr_next;
            if (w_load) begin
                r_op_a <= w_a_s;
                r_op_b <= w_b_s;
            end
        end
    end

    always_comb begin
        w_estado_next = r_estado;
        w_load        = 1'b0;
        w_ovr_next    = 1'b0;
        case (r_estado)
            IDLE: begin
                if (w_press) begin
                    w_load        = 1'b1;
                    w_estado_next = HOLD;
                end
            end
            HOLD: begin
                if (w_press) begin
                    // A transfer on the same edge frees the slot, so the new
                    // press is taken instead of being dropped.
                    if (ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_ovr_next = 1'b1;
                    end
                end else if (ready) begin
                    w_estado_next = IDLE;
                end
            end
            default: w_estado_next = IDLE;
        endcase
    end

    assign valid = (r_estado == HOLD);
    assign _A    = r_op_a;
    assign _B    = r_op_b;
    assign ovr   = r_ovr;

endmodule : ss_entrada_captura
`default_nettype wire

// File: tb/tb_ss_entrada_captura.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ss_entrada_captura
//  Purpose  : Self-checking bench for ss_entrada_captura (WIDTH=8,
//             SYNC_STAGES=2, DEBOUNCE_CYCLES=4). Directed steps followed by a
//             randomised phase, all compared every cycle against a behavioural
//             model. Works with SS_ENTRADA_DEBOUNCE_EN defined or undefined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ss_entrada_captura;

    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;
`ifdef SS_ENTRADA_DEBOUNCE_EN
    localparam int LAT = S + D;   // edge index on which the capture happens
`else
    localparam int LAT = S + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A, B;
    logic         boton, ready;
    wire          valid, ovr;
    wire  [W-1:0] oa, ob;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ss_entrada_captura #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .boton (boton),
        .ready (ready),
        .valid (valid),
        ._A    (oa),
        ._B    (ob),
        .ovr   (ovr)
    );

    // ------------------------------------------------------------------
    // Behavioural model: synchronised values are inputs delayed by S edges;
    // the filtered level switches once the last D synchronised samples all
    // disagree with it; a press is seen one edge after the level rises.
    // ------------------------------------------------------------------
    logic [W-1:0] qa[$], qb[$];
    logic         qbtn[$];
    logic         win[$];
    logic         m_db, m_pend, m_valid, m_ovr;
    logic [W-1:0] m_a, m_b;

    task automatic model_reset();
        qa.delete(); qb.delete(); qbtn.delete(); win.delete();
        for (int i = 0; i < S; i++) begin
            qa.push_back('0); qb.push_back('0); qbtn.push_back(1'b0);
        end
        m_db = 0; m_pend = 0; m_valid = 0; m_ovr = 0; m_a = '0; m_b = '0;
    endtask

    task automatic model_edge();
        logic         bs, press, new_db, all_diff;
        logic [W-1:0] as_, bs_;
        bs  = qbtn.pop_front(); qbtn.push_back(boton);
        as_ = qa.pop_front();   qa.push_back(A);
        bs_ = qb.pop_front();   qb.push_back(B);
        press = m_pend;
`ifdef SS_ENTRADA_DEBOUNCE_EN
        win.push_back(bs);
        if (win.size() > D) void'(win.pop_front());
        all_diff = (win.size() == D);
        foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
        new_db = all_diff ? bs : m_db;
`else
        all_diff = 1'b0;
        new_db   = bs;
`endif
        m_pend = new_db & ~m_db;
        m_db   = new_db;
        m_ovr  = m_valid & ~ready & press;
        if (press && (!m_valid || ready)) begin
            m_a = as_; m_b = bs_; m_valid = 1'b1;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", {31'd0, valid}, {31'd0, m_valid});
        chk("_A",    {24'd0, oa},    {24'd0, m_a});
        chk("_B",    {24'd0, ob},    {24'd0, m_b});
        chk("ovr",   {31'd0, ovr},   {31'd0, m_ovr});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asserts reset mid-cycle, holds it for n edges with random inputs.
    task automatic hold_reset(input int n);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            A = W'($urandom); B = W'($urandom);
            ready = 1'($urandom); boton = 1'($urandom);
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_A",     {24'd0, oa},    32'd0);
            chk("rst_ovr",   {31'd0, ovr},   32'd0);
        end
    endtask

    // Ticks until valid rises (bounded); returns the edge index it rose on.
    task automatic wait_valid(output int e);
        e = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid === 1'b1) begin
                e = i;
                break;
            end
        end
    endtask

    initial begin
        int e;
        int n_ovr;
        rst = 1'b1; A = '0; B = '0; boton = 0; ready = 0;
        model_reset();
        #2;

        // Reset, then a button held from release
        hold_reset(3);
        @(posedge clk); #1;
        rst = 1'b1; boton = 1'b1; ready = 1'b0; A = 8'h3C; B = 8'h96;
        wait_valid(e);
        chk("reset_latency", e, LAT);
        chk("reset_cap_A", {24'd0, oa}, 32'h3C);
        ticks(10);
        chk("held_no_recap", {31'd0, ovr}, 32'd0);

        // Consume, release, clean press
        ready = 1'b1; tick(); ready = 1'b0;
        boton = 1'b0; ticks(S + D + 2);
        A = 8'h5A; B = 8'hC3; boton = 1'b1;
        wait_valid(e);
        chk("clean_latency", e, LAT);
        chk("clean_A", {24'd0, oa}, 32'h5A);
        chk("clean_B", {24'd0, ob}, 32'hC3);
        A = 8'hFF; ticks(5);
        chk("clean_A_hold", {24'd0, oa}, 32'h5A);

        // Handshake, no recapture while held, then re-press
        ready = 1'b1; tick(); ready = 1'b0;
        chk("hs_valid_low", {31'd0, valid}, 32'd0);
        ticks(10);
        chk("hs_no_recap", {31'd0, valid}, 32'd0);
        boton = 1'b0; ticks(S + D + 2);
        A = 8'h11; B = 8'h22; boton = 1'b1;
        wait_valid(e);
        chk("repress_A", {24'd0, oa}, 32'h11);

        // Overrun: press while HOLD and not ready
        boton = 1'b0; ticks(S + D + 2);
        A = 8'h44; B = 8'h55; boton = 1'b1;
        n_ovr = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ovr === 1'b1) n_ovr++;
        end
        chk("ovr_pulses", n_ovr, 1);
        chk("ovr_data", {24'd0, oa}, 32'h11);
        chk("ovr_valid", {31'd0, valid}, 32'd1);

        // Simultaneous transfer and press
        boton = 1'b0; ticks(S + D + 2);
        A = 8'h33; B = 8'h66; boton = 1'b1;
        ticks(LAT);
        ready = 1'b1; tick(); ready = 1'b0;
        chk("sim_valid", {31'd0, valid}, 32'd1);
        chk("sim_A", {24'd0, oa}, 32'h33);
        chk("sim_ovr", {31'd0, ovr}, 32'd0);

        // Short pulse: rejected by debounce, captured without it
        ready = 1'b1; tick(); ready = 1'b0;
        boton = 1'b0; ticks(S + D + 2);
        A = 8'h77;
`ifdef SS_ENTRADA_DEBOUNCE_EN
        boton = 1'b1; ticks(3); boton = 1'b0; ticks(12);
        chk("bounce_valid", {31'd0, valid}, 32'd0);
        chk("bounce_ovr", {31'd0, ovr}, 32'd0);
`else
        boton = 1'b1; tick(); boton = 1'b0;
        e = 0;
        if (valid !== 1'b1) begin
            wait_valid(e);
            e = e + 1;
        end
        chk("pulse_latency", e, LAT);
        chk("pulse_A", {24'd0, oa}, 32'h77);
        ready = 1'b1; tick(); ready = 1'b0;
        ticks(S + 2);
`endif

        // Reset in the middle of a debounce run
        boton = 1'b1; ticks(4);
        hold_reset(2);
        boton = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ticks(12);
        chk("rst_mid_no_cap", {31'd0, valid}, 32'd0);
        A = 8'hA5; boton = 1'b1;
        wait_valid(e);
        chk("rst_mid_fresh_lat", e, LAT);
        chk("rst_mid_fresh_A", {24'd0, oa}, 32'hA5);

        // Randomised phase
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            boton = 1'($urandom);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                A = W'($urandom); B = W'($urandom);
                ready = ($urandom_range(0, 3) == 0);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ss_entrada_captura
`default_nettype wire

// File: doc/ss_entrada_captura.md
# ss_entrada_captura

Parametrised operand-entry subsystem for the Booth multiplier datapath. It synchronises two WIDTH-bit operand buses and a push-button into the `clk` domain, debounces the button, and captures both operands on each debounced press. It presents the operands to the multiplier core through a valid/ready handshake, holding them until consumed, and flags presses lost while a capture is pending.

## Interface
Parameters:
- WIDTH, 4: operand width in bits (≥2)
- SYNC_STAGES, 2: flip-flop stages per synchroniser (≥2)
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to accept a button level change (≥1)

Ports:
- clk  input  1  single system clock
- rst  input  1  reset, asynchronous assert, active-low
- A  input  WIDTH  raw asynchronous operand A
- B  input  WIDTH  raw asynchronous operand B
- boton  input  1  raw asynchronous push-button, active-high
- ready  input  1  core accepts operands this cycle
- valid  output  1  captured operands available
- _A  output  WIDTH  captured operand A
- _B  output  WIDTH  captured operand B
- ovr  output  1  one-cycle pulse: press dropped because a capture was pending

## Operation
- A, B, boton each pass through a SYNC_STAGES flop chain; the synchronised values are `a_s`, `b_s`, `btn_s`.
- Debounce state: level register `db` and counter `cnt` of width $clog2(DEBOUNCE_CYCLES).
  - Each edge with `btn_s == db`: `cnt <= 0`.
  - Each edge with `btn_s != db`: if `cnt == DEBOUNCE_CYCLES-1` then `db <= btn_s`, `cnt <= 0`; else `cnt <= cnt+1`.
- A press event is the edge where `db` goes 0→1. Release (1→0) produces no event, so a held button captures once.
- FSM states: IDLE (valid=0) and HOLD (valid=1).
  - IDLE + press: `_A <= a_s`, `_B <= b_s`, go to HOLD.
  - HOLD + ready=1, no press: go to IDLE. `_A`/`_B` keep their values.
  - HOLD + ready=0 + press: stay in HOLD, data unchanged, `ovr=1` for one cycle.
  - HOLD + ready=1 + press, same edge: the transfer completes, the new operands load, the FSM stays in HOLD, and `ovr=0`.
  - IDLE + ready: ignored.
- Operand changes outside a press event never affect `_A`/`_B`.

## Timing
- Reset (rst=0, asynchronous): all synchroniser flops, `db`, `cnt`, `_A`, `_B` = 0. valid=0, ovr=0, FSM=IDLE. Deasserting rst is clock-synchronous by the system.
- Reset mid-debounce or mid-HOLD discards the pending press or capture. No event follows reset unless the button is seen 0 then 1.
- Latency, debounce on: boton is stable from before edge 0, and valid rises after edge SYNC_STAGES+DEBOUNCE_CYCLES. `_A`/`_B` are valid on the same edge.
- Operands must be stable for SYNC_STAGES cycles before that capture edge. Operand stability is a user-level requirement, not checked.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is fully rejected.
- Handshake: the transfer occurs on an edge with valid=1 and ready=1. valid falls after that edge unless the simultaneous-press case applies. valid never drops without ready.
- ovr is registered, high for exactly one cycle after the dropping edge.

## Configuration
- SS_ENTRADA_DEBOUNCE_EN defined: debounce as described.
- SS_ENTRADA_DEBOUNCE_EN undefined: no counter. Each edge `db <= btn_s`, so valid rises after edge SYNC_STAGES+1, and DEBOUNCE_CYCLES is ignored.
- Both builds have identical ports.

## Structure
- Package `ss_entrada_pkg`:
  - state enum `estado_t` {IDLE, HOLD}
  - default parameter constants: DEF_WIDTH=4, DEF_SYNC_STAGES=2, DEF_DEBOUNCE_CYCLES=16
- One sub-module, `antirrebote`: synchroniser chain plus `db`/`cnt` logic for the button. It outputs `db` and a one-cycle rise pulse.
- Operand synchronisers, FSM and capture registers stay in the top module.

## Test plan
All tests use WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, with the macro defined unless stated.
- Reset: hold rst=0 with random inputs -> valid=0, ovr=0, _A=_B=8'h00. Release, then hold boton=1 constant -> one capture after 6 edges.
- Clean press: A=8'h5A, B=8'hC3, boton 0→1 before edge 0, ready=0 -> valid=1 after edge 6 with _A=5A, _B=C3. Change A to 8'hFF while held -> outputs unchanged.
- Bounce: boton high for 3 cycles then low -> valid stays 0 and ovr stays 0.
- Handshake: valid=1, assert ready one cycle -> valid=0 next edge. Keep button held -> no recapture. Release ≥4 cycles, repress with A=8'h11 -> new capture 8'h11.
- Overrun/simultaneous: valid=1, ready=0, new debounced press -> ovr pulse 1 cycle, data unchanged. Repeat with ready=1 on the press edge -> new data loads, valid stays 1, ovr=0.
- Macro undefined, plus reset mid-debounce: a 1-cycle boton pulse -> capture after edge 3. With the macro defined, drive rst=0 at count 2 -> no capture until a fresh 0→1 press.
